rs_mult_seq: RTL

//  Sequencer for the serial right-shift (shift-add) multiplier. Accepts an operand pair over
//  a valid/ready handshake, clears the datapath, feeds multiplier bits LSB-first for N cycles,

---
 rtl/rs_mult_pkg.sv | 18 +
 rtl/rs_mult_dp.sv | 46 ++++
 rtl/rs_mult_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rs_mult_pkg.sv
// Shared types and constants for the serial right-shift multiplier sequencer.
package rs_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rs_state_e;

  localparam int RS_N_DEFAULT = 6;
  localparam int RS_PERF_W    = 16;

  // Counter width able to hold the values 0..n.
  function automatic int rs_cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rs_mult_dp.sv
// One-bit shift-add datapath step: P <= (P + (x ? y<<N : 0)) >> 1, summed at 2N+1 bits.
module rs_mult_dp
  import rs_mult_pkg::*;
#(
  parameter int N = RS_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           step,
  input  logic           x_bit,
  input  logic [N-1:0]   y_in,
  output logic [2*N-1:0] p_next
);

  logic [N-1:0]   y_r;
  logic [2*N-1:0] p_r;
  logic [2*N:0]   addend_s;
  logic [2*N:0]   sum_s;

  // Multiplicand aligned to the upper half; the extra top bit keeps the carry.
  always_comb begin
    addend_s = {(2*N+1){1'b0}};
    if (x_bit) begin
      addend_s = {1'b0, y_r, {N{1'b0}}};
    end else begin
      addend_s = {(2*N+1){1'b0}};
    end
    sum_s  = {1'b0, p_r} + addend_s;
    p_next = sum_s[2*N:1];
  end

  // Partial-product and multiplicand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r <= {N{1'b0}};
      p_r <= {(2*N){1'b0}};
    end else if (clr) begin
      y_r <= y_in;
      p_r <= {(2*N){1'b0}};
    end else if (step) begin
      p_r <= p_next;
    end
  end

endmodule

// File: rtl/rs_mult_seq.sv
// Sequencer for the serial shift-add multiplier: handshake, FSM, x shift register.
// Optional feature macro RS_MULT_PERF_CNT_EN adds a 16-bit completed-product counter.
module rs_mult_seq
  import rs_mult_pkg::*;
#(
  parameter int N  = RS_N_DEFAULT,
  parameter int CW = rs_cw(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic           busy,
  output logic [CW-1:0]  count_out
`ifdef RS_MULT_PERF_CNT_EN
  ,
  output logic [RS_PERF_W-1:0] perf_cnt
`else
`endif
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]     state_r;
  logic [CW-1:0]  count_r;
  logic [N-1:0]   xreg_r;
  logic [2*N-1:0] out_p_r;
  logic           in_ready_r;
  logic           out_valid_r;
  logic           busy_r;
  logic           accept_s;
  logic           step_s;
  logic           last_s;
  logic           handshake_s;
  logic [2*N-1:0] p_next_s;

  // Control decodes from registered state.
  always_comb begin
    accept_s    = in_valid && in_ready_r;
    step_s      = (state_r == SHIFT);
    last_s      = step_s && (count_r == CW'(N - 1));
    handshake_s = out_valid_r && out_ready;
  end

  rs_mult_dp #(.N(N)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept_s),
    .step   (step_s),
    .x_bit  (xreg_r[0]),
    .y_in   (in_y),
    .p_next (p_next_s)
  );

  // FSM, shift counter, multiplier shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      xreg_r      <= {N{1'b0}};
      out_p_r     <= {(2*N){1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r    <= SHIFT;
            xreg_r     <= in_x;
            count_r    <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        SHIFT: begin
          xreg_r  <= xreg_r >> 1;
          count_r <= count_r + CW'(1);
          // Final step: capture the completed product straight from the adder.
          if (last_s) begin
            state_r     <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            out_p_r     <= p_next_s;
          end
        end
        DONE: begin
          if (handshake_s) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            count_r     <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          count_r     <= {CW{1'b0}};
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_p     = out_p_r;
  assign busy      = busy_r;
  assign count_out = count_r;

`ifdef RS_MULT_PERF_CNT_EN
  logic [RS_PERF_W-1:0] perf_r;

  // Completed-product counter; wraps naturally at the top of its range.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_r <= {RS_PERF_W{1'b0}};
    end else if (handshake_s) begin
      perf_r <= perf_r + RS_PERF_W'(1);
    end
  end

  assign perf_cnt = perf_r;
`else
  // No completed-product counter in this build.
`endif

endmodule
